button_event_mmio: RTL and testbench



---
 rtl/button_event_mmio_pkg.sv | 27 ++
 rtl/button_event_mmio_btn_debounce.sv | 51 +++++
 rtl/button_event_mmio.sv | 120 ++++++++++++
 tb/tb_button_event_mmio.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_mmio_pkg.sv
// Shared definitions for the Sly-Man-Says player-input stage and its MMIO neighbours.
// Colour codes are shared with the LED flasher so presses can be echoed directly.
package button_event_mmio_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    BLUE   = 2'd1,
    GREEN  = 2'd2,
    YELLOW = 2'd3
  } colour_t;

  localparam logic [11:0] RANDOM_ADDR = 12'd5;
  localparam logic [11:0] LED_ADDR    = 12'd6;
  localparam logic [11:0] BTN_ADDR    = 12'd7;

  localparam int RD_VALID_BIT  = 0;
  localparam int RD_COLOUR_LSB = 1;
  localparam int RD_COLOUR_MSB = 2;
  localparam int RD_COUNT_LSB  = 3;
  localparam int RD_COUNT_MSB  = 5;
  localparam int RD_OVF_BIT    = 6;

  localparam int CMD_POP_BIT     = 0;
  localparam int CMD_CLR_OVF_BIT = 1;
  localparam int CMD_FLUSH_BIT   = 2;

endpackage

// File: rtl/button_event_mmio_btn_debounce.sv
// One pushbutton: 2-flop synchroniser, stability counter, and a registered
// single-cycle pulse on each accepted release-to-press transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic [CNT_W-1:0] count_reg;
  logic             stable_reg;
  logic             stable_prev_reg;
  logic             press_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_reg       <= 1'b0;
      sync2_reg       <= 1'b0;
      count_reg       <= '0;
      stable_reg      <= 1'b0;
      stable_prev_reg <= 1'b0;
      press_reg       <= 1'b0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      // Any sample agreeing with the stable level restarts the qualification window.
      if (sync2_reg != stable_reg) begin
        if (count_reg == CNT_LAST) begin
          stable_reg <= sync2_reg;
          count_reg  <= '0;
        end else begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end else begin
        count_reg <= '0;
      end
      stable_prev_reg <= stable_reg;
      press_reg       <= stable_reg & ~stable_prev_reg;
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/button_event_mmio.sv
// Debounced colour-button event FIFO, polled by the processor at one data word
// address (status/head word on read, pop/clear-overflow/flush on write).
module button_event_mmio
  import button_event_mmio_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [11:0] MMIO_ADDR       = BTN_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  btn_raw,
  input  logic [11:0] mem_addr,
  input  logic        mem_wren,
  input  logic [31:0] mem_wdata,
  output logic        addr_hit,
  output logic [31:0] rd_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [2:0] DEPTH_COUNT = 3'(FIFO_DEPTH);

  logic [3:0] press;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clock  (clock),
        .reset  (reset),
        .btn_raw(btn_raw[gi]),
        .press  (press[gi])
      );
    end
  endgenerate

  // Lowest-index press wins; coincident presses beyond it are lost.
  colour_t push_colour;
  always_comb begin
    push_colour = RED;
    for (int i = 3; i >= 0; i--) begin
      if (press[i]) push_colour = colour_t'(i[1:0]);
    end
  end

  logic press_any;
  logic press_multi;
  assign press_any   = |press;
  assign press_multi = (press & (press - 4'd1)) != 4'd0;

  assign addr_hit = (mem_addr == MMIO_ADDR);

  logic cmd_valid;
  logic cmd_pop;
  logic cmd_clr_ovf;
  logic cmd_flush;
  assign cmd_valid   = mem_wren && addr_hit;
  assign cmd_pop     = cmd_valid && mem_wdata[CMD_POP_BIT];
  assign cmd_clr_ovf = cmd_valid && mem_wdata[CMD_CLR_OVF_BIT];
  assign cmd_flush   = cmd_valid && mem_wdata[CMD_FLUSH_BIT];

  logic unused_wdata;
  assign unused_wdata = ^mem_wdata[31:CMD_FLUSH_BIT+1];

  colour_t           fifo_mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [2:0]        count_reg;
  logic              ovf_reg;

  logic fifo_full;
  logic fifo_empty;
  logic pop_eff;
  logic push_eff;
  logic drop_full;
  logic ovf_set;

  assign fifo_full  = (count_reg == DEPTH_COUNT);
  assign fifo_empty = (count_reg == 3'd0);
  assign pop_eff    = cmd_pop && !cmd_flush && !fifo_empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push_eff   = press_any && !cmd_flush && (!fifo_full || pop_eff);
  assign drop_full  = press_any && !cmd_flush && fifo_full && !pop_eff;
  assign ovf_set    = press_multi || drop_full;

  always_ff @(posedge clock) begin
    if (push_eff) fifo_mem_reg[wr_ptr_reg] <= push_colour;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= 3'd0;
      ovf_reg    <= 1'b0;
    end else begin
      if (cmd_flush) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= 3'd0;
      end else begin
        if (push_eff) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_reg + 3'(push_eff) - 3'(pop_eff);
      end
      ovf_reg <= ovf_set | (ovf_reg & ~cmd_clr_ovf);
    end
  end

  always_comb begin
    rd_data = '0;
    rd_data[RD_VALID_BIT] = !fifo_empty;
    if (!fifo_empty) rd_data[RD_COLOUR_MSB:RD_COLOUR_LSB] = fifo_mem_reg[rd_ptr_reg];
    rd_data[RD_COUNT_MSB:RD_COUNT_LSB] = count_reg;
    rd_data[RD_OVF_BIT] = ovf_reg;
  end

endmodule

// File: tb/tb_button_event_mmio.sv
// Directed bench for button_event_mmio: latency, glitch rejection, FIFO order,
// overflow/flush commands, same-cycle push/pop corners and reset mid-operation.
module tb_button_event_mmio;

  localparam int D = 16;

  logic        clock;
  logic        reset;
  logic [3:0]  btn_raw;
  logic [11:0] mem_addr;
  logic        mem_wren;
  logic [31:0] mem_wdata;
  logic        addr_hit;
  logic [31:0] rd_data;

  int n_compared;
  int n_mismatched;

  button_event_mmio #(
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (4),
    .MMIO_ADDR      (12'd7)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .mem_addr (mem_addr),
    .mem_wren (mem_wren),
    .mem_wdata(mem_wdata),
    .addr_hit (addr_hit),
    .rd_data  (rd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    btn_raw   = 4'b0000;
    mem_wren  = 1'b0;
    mem_wdata = 32'h0;
    mem_addr  = 12'd7;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic sw(input logic [11:0] addr, input logic [31:0] data);
    mem_addr  = addr;
    mem_wdata = data;
    mem_wren  = 1'b1;
    tick(1);
    mem_wren  = 1'b0;
    mem_wdata = 32'h0;
    mem_addr  = 12'd7;
    $display("sw 0x%0h to addr %0d -> rd_data=0x%08h", data, addr, rd_data);
  endtask

  task automatic press_btn(input logic [3:0] mask);
    btn_raw = mask;
    tick(D + 8);
    btn_raw = 4'b0000;
    tick(D + 8);
    $display("press %b -> rd_data=0x%08h", mask, rd_data);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    btn_raw   = 4'b1111;
    mem_wren  = 1'b0;
    mem_wdata = 32'h0;
    mem_addr  = 12'd7;
    tick(2);
    if (rd_data !== 32'h0) begin
      n_mismatched++;
      $display("FAIL reset_rd_data: got 0x%08h required 0x%08h", rd_data, 32'h0);
    end
    n_compared++;
    if (addr_hit !== 1'b1) begin
      n_mismatched++;
      $display("FAIL reset_addr_hit7: got %b required 1", addr_hit);
    end
    n_compared++;
    mem_addr = 12'd6;
    #1;
    if (addr_hit !== 1'b0) begin
      n_mismatched++;
      $display("FAIL addr_hit6: got %b required 0", addr_hit);
    end
    n_compared++;
    btn_raw  = 4'b0000;
    mem_addr = 12'd7;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    btn_raw = 4'b0100;
    tick(D + 3);
    if (rd_data !== 32'h0) begin
      n_mismatched++;
      $display("FAIL latency_early: got 0x%08h required 0x%08h", rd_data, 32'h0);
    end
    n_compared++;
    tick(1);
    if (rd_data !== 32'h0000_000D) begin
      n_mismatched++;
      $display("FAIL latency_green: got 0x%08h required 0x%08h", rd_data, 32'h0000_000D);
    end
    n_compared++;
    tick(3);
    if (rd_data !== 32'h0000_000D) begin
      n_mismatched++;
      $display("FAIL read_nondestructive: got 0x%08h required 0x%08h", rd_data, 32'h0000_000D);
    end
    n_compared++;
    tick(8);
    btn_raw = 4'b0000;
    tick(D + 8);
    if (rd_data !== 32'h0000_000D) begin
      n_mismatched++;
      $display("FAIL release_no_event: got 0x%08h required 0x%08h", rd_data, 32'h0000_000D);
    end
    n_compared++;
  endtask

  task automatic test_glitch_and_pop();
    do_reset();
    btn_raw = 4'b0010;
    tick(10);
    btn_raw = 4'b0000;
    tick(30);
    if (rd_data !== 32'h0) begin
      n_mismatched++;
      $display("FAIL glitch: got 0x%08h required 0x%08h", rd_data, 32'h0);
    end
    n_compared++;
    press_btn(4'b0001);
    press_btn(4'b0010);
    press_btn(4'b1000);
    sw(12'd6, 32'h7);
    if (rd_data !== 32'h19) begin
      n_mismatched++;
      $display("FAIL head_red_cnt3: got 0x%08h required 0x%08h", rd_data, 32'h19);
    end
    n_compared++;
    sw(12'd7, 32'h1);
    if (rd_data !== 32'h13) begin
      n_mismatched++;
      $display("FAIL head_blue_cnt2: got 0x%08h required 0x%08h", rd_data, 32'h13);
    end
    n_compared++;
    sw(12'd7, 32'h1);
    if (rd_data !== 32'h0F) begin
      n_mismatched++;
      $display("FAIL head_yellow_cnt1: got 0x%08h required 0x%08h", rd_data, 32'h0F);
    end
    n_compared++;
    sw(12'd7, 32'h1);
    if (rd_data !== 32'h0) begin
      n_mismatched++;
      $display("FAIL drained: got 0x%08h required 0x%08h", rd_data, 32'h0);
    end
    n_compared++;
    sw(12'd7, 32'h1);
    if (rd_data !== 32'h0) begin
      n_mismatched++;
      $display("FAIL pop_when_empty: got 0x%08h required 0x%08h", rd_data, 32'h0);
    end
    n_compared++;
  endtask

  task automatic test_overflow_flush();
    do_reset();
    press_btn(4'b0001);
    press_btn(4'b0010);
    press_btn(4'b0100);
    press_btn(4'b1000);
    press_btn(4'b0001);
    if (rd_data !== 32'h61) begin
      n_mismatched++;
      $display("FAIL full_overflow: got 0x%08h required 0x%08h", rd_data, 32'h61);
    end
    n_compared++;
    sw(12'd7, 32'h2);
    if (rd_data !== 32'h21) begin
      n_mismatched++;
      $display("FAIL clear_ovf: got 0x%08h required 0x%08h", rd_data, 32'h21);
    end
    n_compared++;
    sw(12'd7, 32'h1);
    if (rd_data !== 32'h1B) begin
      n_mismatched++;
      $display("FAIL pop_after_full: got 0x%08h required 0x%08h", rd_data, 32'h1B);
    end
    n_compared++;
    sw(12'd7, 32'h4);
    if (rd_data !== 32'h0) begin
      n_mismatched++;
      $display("FAIL flush: got 0x%08h required 0x%08h", rd_data, 32'h0);
    end
    n_compared++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    press_btn(4'b0001);
    press_btn(4'b0010);
    press_btn(4'b0100);
    press_btn(4'b1000);
    btn_raw = 4'b0001;
    tick(D + 3);
    mem_addr  = 12'd7;
    mem_wdata = 32'h1;
    mem_wren  = 1'b1;
    tick(1);
    mem_wren  = 1'b0;
    mem_wdata = 32'h0;
    $display("sw 0x1 to addr 7 with coincident press -> rd_data=0x%08h", rd_data);
    if (rd_data !== 32'h23) begin
      n_mismatched++;
      $display("FAIL full_push_pop: got 0x%08h required 0x%08h", rd_data, 32'h23);
    end
    n_compared++;
    btn_raw = 4'b0000;
    tick(D + 8);
    sw(12'd7, 32'h1);
    if (rd_data !== 32'h1D) begin
      n_mismatched++;
      $display("FAIL drain_green: got 0x%08h required 0x%08h", rd_data, 32'h1D);
    end
    n_compared++;
    sw(12'd7, 32'h1);
    if (rd_data !== 32'h17) begin
      n_mismatched++;
      $display("FAIL drain_yellow: got 0x%08h required 0x%08h", rd_data, 32'h17);
    end
    n_compared++;
    sw(12'd7, 32'h1);
    if (rd_data !== 32'h09) begin
      n_mismatched++;
      $display("FAIL drain_new_red_tail: got 0x%08h required 0x%08h", rd_data, 32'h09);
    end
    n_compared++;
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    btn_raw = 4'b0010;
    tick(D + 3);
    mem_addr  = 12'd7;
    mem_wdata = 32'h1;
    mem_wren  = 1'b1;
    tick(1);
    mem_wren  = 1'b0;
    mem_wdata = 32'h0;
    $display("sw 0x1 to addr 7 on empty with coincident press -> rd_data=0x%08h", rd_data);
    if (rd_data !== 32'h0B) begin
      n_mismatched++;
      $display("FAIL empty_push_pop: got 0x%08h required 0x%08h", rd_data, 32'h0B);
    end
    n_compared++;
    btn_raw = 4'b0000;
    tick(D + 8);
  endtask

  task automatic test_simultaneous();
    do_reset();
    press_btn(4'b1001);
    if (rd_data !== 32'h49) begin
      n_mismatched++;
      $display("FAIL simultaneous_red: got 0x%08h required 0x%08h", rd_data, 32'h49);
    end
    n_compared++;
    sw(12'd7, 32'h1);
    if (rd_data !== 32'h40) begin
      n_mismatched++;
      $display("FAIL ovf_sticky: got 0x%08h required 0x%08h", rd_data, 32'h40);
    end
    n_compared++;
    sw(12'd7, 32'h2);
    if (rd_data !== 32'h0) begin
      n_mismatched++;
      $display("FAIL ovf_cleared: got 0x%08h required 0x%08h", rd_data, 32'h0);
    end
    n_compared++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_btn(4'b0001);
    press_btn(4'b0010);
    press_btn(4'b0100);
    if (rd_data !== 32'h19) begin
      n_mismatched++;
      $display("FAIL queued3: got 0x%08h required 0x%08h", rd_data, 32'h19);
    end
    n_compared++;
    btn_raw = 4'b0100;
    tick(5);
    reset = 1'b1;
    tick(1);
    if (rd_data !== 32'h0) begin
      n_mismatched++;
      $display("FAIL mid_reset_clear: got 0x%08h required 0x%08h", rd_data, 32'h0);
    end
    n_compared++;
    tick(1);
    reset = 1'b0;
    tick(D + 3);
    if (rd_data !== 32'h0) begin
      n_mismatched++;
      $display("FAIL held_early: got 0x%08h required 0x%08h", rd_data, 32'h0);
    end
    n_compared++;
    tick(1);
    if (rd_data !== 32'h0D) begin
      n_mismatched++;
      $display("FAIL held_green_event: got 0x%08h required 0x%08h", rd_data, 32'h0D);
    end
    n_compared++;
    tick(60);
    if (rd_data !== 32'h0D) begin
      n_mismatched++;
      $display("FAIL held_no_repeat: got 0x%08h required 0x%08h", rd_data, 32'h0D);
    end
    n_compared++;
    btn_raw = 4'b0000;
    tick(D + 14);
    if (rd_data !== 32'h0D) begin
      n_mismatched++;
      $display("FAIL held_release: got 0x%08h required 0x%08h", rd_data, 32'h0D);
    end
    n_compared++;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset     = 1'b1;
    btn_raw   = 4'b0000;
    mem_addr  = 12'd7;
    mem_wren  = 1'b0;
    mem_wdata = 32'h0;
    test_reset();
    test_latency();
    test_glitch_and_pop();
    test_overflow_flush();
    test_full_push_pop();
    test_empty_push_pop();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
